// File: rtl/dma_job_launcher.sv
// ============================================================================
// dma_job_launcher: programs the 2D iDMA register frontend for one job at a
// time, polls DONE_ID and returns a completion record.
// Optional feature macro: DMA_JOB_LAUNCHER_TIMEOUT_EN (bounded polling).
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_job_launcher #(
  parameter int unsigned          AddrWidth    = 64,
  parameter int unsigned          LenWidth     = 32,
  parameter logic [AddrWidth-1:0] RegBase      = '0,
  parameter int unsigned          PollInterval = 16,
  parameter int unsigned          MaxPolls     = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [AddrWidth-1:0] job_src_i,
  input  logic [AddrWidth-1:0] job_dst_i,
  input  logic [LenWidth-1:0]  job_len_i,
  input  logic [7:0]           job_conf_i,
  input  logic [63:0]          job_src_stride_i,
  input  logic [63:0]          job_dst_stride_i,
  input  logic [63:0]          job_reps_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [31:0]          done_id_o,
  output logic [1:0]           done_err_o,
  output logic                 reg_valid_o,
  output logic                 reg_write_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic [63:0]          reg_wdata_o,
  output logic [7:0]           reg_wstrb_o,
  input  logic                 reg_ready_i,
  input  logic [63:0]          reg_rdata_i,
  input  logic                 reg_error_i
);

  localparam int unsigned CntW = $clog2(PollInterval + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_CONF, ST_WR_SRC, ST_WR_DST, ST_WR_LEN, ST_WR_DST_STRIDE,
    ST_WR_SRC_STRIDE, ST_WR_REPS, ST_RD_NEXT, ST_WAIT, ST_RD_DONE, ST_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [7:0]           conf_q, conf_d;
  logic [63:0]          sstr_q, sstr_d, dstr_q, dstr_d, reps_q, reps_d;
  logic [31:0]          id_q, id_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 job_ready_q, job_ready_d;
  logic                 done_valid_q, done_valid_d;
  logic [31:0]          done_id_q, done_id_d;
  logic [1:0]           done_err_q, done_err_d;
  logic                 reg_valid_q, reg_valid_d, reg_write_q, reg_write_d;
  logic [AddrWidth-1:0] reg_addr_q, reg_addr_d;
  logic [63:0]          reg_wdata_q, reg_wdata_d;
  logic [7:0]           reg_wstrb_q, reg_wstrb_d, off;
  logic                 acc;
  logic [31:0]          diff;
`ifdef DMA_JOB_LAUNCHER_TIMEOUT_EN
  logic [15:0]          poll_q, poll_d;
`else
  logic                 unused_maxpolls;
  assign unused_maxpolls = (MaxPolls == 0);
`endif
  logic                 unused_rdata;
  assign unused_rdata = ^reg_rdata_i[63:32];

  assign acc  = reg_valid_q & reg_ready_i;
  // Serial-number comparison so DONE_ID wrapping past 2^32 still retires the job.
  assign diff = reg_rdata_i[31:0] - id_q;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    conf_d     = conf_q;
    sstr_d     = sstr_q;
    dstr_d     = dstr_q;
    reps_d     = reps_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    done_err_d = done_err_q;
`ifdef DMA_JOB_LAUNCHER_TIMEOUT_EN
    poll_d     = poll_q;
`endif
    case (state_q)
      ST_IDLE: if (job_valid_i && job_ready_q) begin
        src_d   = job_src_i;
        dst_d   = job_dst_i;
        len_d   = job_len_i;
        conf_d  = job_conf_i;
        sstr_d  = job_src_stride_i;
        dstr_d  = job_dst_stride_i;
        reps_d  = job_reps_i;
        id_d    = '0;
        state_d = ST_WR_CONF;
      end
      ST_WR_CONF:       if (acc) state_d = ST_WR_SRC;
      ST_WR_SRC:        if (acc) state_d = ST_WR_DST;
      ST_WR_DST:        if (acc) state_d = ST_WR_LEN;
      ST_WR_LEN:        if (acc) state_d = conf_q[3] ? ST_WR_DST_STRIDE : ST_RD_NEXT;
      ST_WR_DST_STRIDE: if (acc) state_d = ST_WR_SRC_STRIDE;
      ST_WR_SRC_STRIDE: if (acc) state_d = ST_WR_REPS;
      ST_WR_REPS:       if (acc) state_d = ST_RD_NEXT;
      ST_RD_NEXT: if (acc) begin
        id_d  = reg_rdata_i[31:0];
        cnt_d = '0;
`ifdef DMA_JOB_LAUNCHER_TIMEOUT_EN
        poll_d = '0;
`endif
        if (reg_rdata_i[31:0] == 32'd0) begin
          state_d    = ST_RESP;
          done_err_d = 2'd2;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CntW'(PollInterval - 1)) state_d = ST_RD_DONE;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      ST_RD_DONE: if (acc) begin
        cnt_d = '0;
        if (!diff[31]) begin
          state_d    = ST_RESP;
          done_err_d = 2'd0;
        end else begin
          state_d = ST_WAIT;
`ifdef DMA_JOB_LAUNCHER_TIMEOUT_EN
          poll_d = poll_q + 1'b1;
          if ({16'd0, poll_q} + 32'd1 >= 32'(MaxPolls)) begin
            state_d    = ST_RESP;
            done_err_d = 2'd3;
          end
`endif
        end
      end
      ST_RESP: if (done_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (acc && reg_error_i) begin
      state_d    = ST_RESP;
      done_err_d = 2'd1;
    end

    job_ready_d  = (state_d == ST_IDLE);
    done_valid_d = (state_d == ST_RESP);
    done_id_d    = (state_d == ST_RESP && state_q != ST_RESP) ? id_d : done_id_q;

    // Request fields follow the next state so they appear on the entry cycle.
    reg_valid_d = 1'b1;
    reg_write_d = 1'b1;
    reg_wdata_d = '0;
    off         = '0;
    case (state_d)
      ST_WR_CONF:       begin off = 8'h00; reg_wdata_d = {56'd0, conf_d}; end
      ST_WR_SRC:        begin off = 8'hD8; reg_wdata_d = 64'(src_d); end
      ST_WR_DST:        begin off = 8'hD0; reg_wdata_d = 64'(dst_d); end
      ST_WR_LEN:        begin off = 8'hE0; reg_wdata_d = 64'(len_d); end
      ST_WR_DST_STRIDE: begin off = 8'hE8; reg_wdata_d = dstr_d; end
      ST_WR_SRC_STRIDE: begin off = 8'hF0; reg_wdata_d = sstr_d; end
      ST_WR_REPS:       begin off = 8'hF8; reg_wdata_d = reps_d; end
      ST_RD_NEXT:       begin off = 8'h10; reg_write_d = 1'b0; end
      ST_RD_DONE:       begin off = 8'h18; reg_write_d = 1'b0; end
      default:          begin reg_valid_d = 1'b0; reg_write_d = 1'b0; end
    endcase
    reg_addr_d  = reg_valid_d ? RegBase + AddrWidth'(off) : '0;
    reg_wstrb_d = (reg_valid_d && reg_write_d) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      conf_q       <= '0;
      sstr_q       <= '0;
      dstr_q       <= '0;
      reps_q       <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      job_ready_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= '0;
      reg_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_wstrb_q  <= '0;
`ifdef DMA_JOB_LAUNCHER_TIMEOUT_EN
      poll_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      conf_q       <= conf_d;
      sstr_q       <= sstr_d;
      dstr_q       <= dstr_d;
      reps_q       <= reps_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      job_ready_q  <= job_ready_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_err_q   <= done_err_d;
      reg_valid_q  <= reg_valid_d;
      reg_write_q  <= reg_write_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wstrb_q  <= reg_wstrb_d;
`ifdef DMA_JOB_LAUNCHER_TIMEOUT_EN
      poll_q       <= poll_d;
`endif
    end
  end

  assign job_ready_o  = job_ready_q;
  assign done_valid_o = done_valid_q;
  assign done_id_o    = done_id_q;
  assign done_err_o   = done_err_q;
  assign reg_valid_o  = reg_valid_q;
  assign reg_write_o  = reg_write_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign reg_wstrb_o  = reg_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_job_launcher.sv
// ============================================================================
// tb_dma_job_launcher: directed bench with a register-bus responder and log.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_job_launcher;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [63:0] job_src_i = '0, job_dst_i = '0;
  logic [31:0] job_len_i = '0;
  logic [7:0]  job_conf_i = '0;
  logic [63:0] job_src_stride_i = '0, job_dst_stride_i = '0, job_reps_i = '0;
  logic        done_valid_o;
  logic        done_ready_i = 1'b0;
  logic [31:0] done_id_o;
  logic [1:0]  done_err_o;
  logic        reg_valid_o, reg_write_o;
  logic [63:0] reg_addr_o, reg_wdata_o;
  logic [7:0]  reg_wstrb_o;
  logic        reg_ready_i, reg_error_i;
  logic [63:0] reg_rdata_i;

  logic        bus_hold = 1'b0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;
  logic [31:0] next_id_val = '0;
  logic [31:0] done_seq [4];
  int          rd18_cnt = 0, rd18_base = 0, n_log = 0, cyc = 0;
  logic [63:0] log_addr [256];
  logic [63:0] log_data [256];
  logic [7:0]  log_strb [256];
  logic        log_wr   [256];
  int          log_cyc  [256];
  int          n_cmp = 0, n_err = 0;

  dma_job_launcher dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_src_i(job_src_i), .job_dst_i(job_dst_i), .job_len_i(job_len_i),
    .job_conf_i(job_conf_i), .job_src_stride_i(job_src_stride_i),
    .job_dst_stride_i(job_dst_stride_i), .job_reps_i(job_reps_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_id_o(done_id_o), .done_err_o(done_err_o),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i)
  );

  always #5 clk_i = ~clk_i;

  assign reg_ready_i = reg_valid_o & ~bus_hold;
  assign reg_error_i = reg_ready_i & err_en & (reg_addr_o == err_addr);

  always_comb begin
    int k;
    k = rd18_cnt - rd18_base;
    if (k > 3) k = 3;
    if (k < 0) k = 0;
    reg_rdata_i = 64'd0;
    if (reg_addr_o == 64'h10)      reg_rdata_i = {32'd0, next_id_val};
    else if (reg_addr_o == 64'h18) reg_rdata_i = {32'd0, done_seq[k]};
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_ni && reg_valid_o && reg_ready_i) begin
      if (n_log < 256) begin
        log_addr[n_log] <= reg_addr_o;
        log_data[n_log] <= reg_wdata_o;
        log_strb[n_log] <= reg_wstrb_o;
        log_wr[n_log]   <= reg_write_o;
        log_cyc[n_log]  <= cyc;
      end
      n_log <= n_log + 1;
      if (!reg_write_o && reg_addr_o == 64'h18) rd18_cnt <= rd18_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic wr,
                           input logic [63:0] addr, input logic [63:0] data);
    if (idx >= n_log || idx >= 256) begin
      check_eq({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_wr"},   64'(log_wr[idx]), 64'(wr));
      check_eq({tag, "_addr"}, log_addr[idx], addr);
      check_eq({tag, "_strb"}, 64'(log_strb[idx]), wr ? 64'hFF : 64'h00);
      if (wr) check_eq({tag, "_data"}, log_data[idx], data);
    end
  endtask

  function automatic int count_rd18(input int from);
    int c = 0;
    for (int i = from; i < n_log && i < 256; i++)
      if (!log_wr[i] && log_addr[i] == 64'h18) c++;
    return c;
  endfunction

  task automatic start_job(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] len,
                           input logic [7:0] conf, input logic [63:0] sstr, input logic [63:0] dstr,
                           input logic [63:0] reps, output int base);
    int n = 0;
    @(negedge clk_i);
    while (!job_ready_o && n < 50) begin @(negedge clk_i); n++; end
    check_eq("job_ready", 64'(job_ready_o), 64'd1);
    base = n_log;
    rd18_base = rd18_cnt;
    job_src_i = src; job_dst_i = dst; job_len_i = len; job_conf_i = conf;
    job_src_stride_i = sstr; job_dst_stride_i = dstr; job_reps_i = reps;
    job_valid_i = 1'b1;
    @(negedge clk_i);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_valid_o && n < 3000) begin @(negedge clk_i); n++; end
    if (!done_valid_o) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_done(input logic [31:0] id, input logic [1:0] err);
    check_eq("done_valid", 64'(done_valid_o), 64'd1);
    check_eq("done_id", 64'(done_id_o), 64'(id));
    check_eq("done_err", 64'(done_err_o), 64'(err));
    done_ready_i = 1'b1;
    @(negedge clk_i);
    done_ready_i = 1'b0;
    check_eq("done_drop", 64'(done_valid_o), 64'd0);
  endtask

  initial begin
    int base, n, pc;
    done_seq = '{32'd0, 32'd0, 32'd0, 32'd0};
    repeat (3) @(negedge clk_i);
    check_eq("rst_job_ready", 64'(job_ready_o), 64'd0);
    check_eq("rst_reg_valid", 64'(reg_valid_o), 64'd0);
    check_eq("rst_done_valid", 64'(done_valid_o), 64'd0);
    check_eq("rst_addr", reg_addr_o, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("post_rst_ready", 64'(job_ready_o), 64'd1);

    // 1D job, immediate completion
    next_id_val = 32'd5;
    done_seq = '{32'd5, 32'd5, 32'd5, 32'd5};
    start_job(64'h1000, 64'h2000, 32'h40, 8'h00, 64'h0, 64'h0, 64'h0, base);
    check_eq("busy_not_ready", 64'(job_ready_o), 64'd0);
    wait_done();
    check_log("t1_conf", base + 0, 1'b1, 64'h00, 64'h0);
    check_log("t1_src",  base + 1, 1'b1, 64'hD8, 64'h1000);
    check_log("t1_dst",  base + 2, 1'b1, 64'hD0, 64'h2000);
    check_log("t1_len",  base + 3, 1'b1, 64'hE0, 64'h40);
    check_log("t1_next", base + 4, 1'b0, 64'h10, 64'h0);
    check_log("t1_done", base + 5, 1'b0, 64'h18, 64'h0);
    check_eq("t1_count", 64'(n_log - base), 64'd6);
    finish_done(32'd5, 2'd0);

    // 2D job, seven writes then NEXT_ID
    start_job(64'h3000, 64'h4000, 32'h80, 8'h08, 64'h100, 64'h200, 64'd4, base);
    wait_done();
    check_log("t2_conf", base + 0, 1'b1, 64'h00, 64'h08);
    check_log("t2_src",  base + 1, 1'b1, 64'hD8, 64'h3000);
    check_log("t2_dst",  base + 2, 1'b1, 64'hD0, 64'h4000);
    check_log("t2_len",  base + 3, 1'b1, 64'hE0, 64'h80);
    check_log("t2_dstr", base + 4, 1'b1, 64'hE8, 64'h200);
    check_log("t2_sstr", base + 5, 1'b1, 64'hF0, 64'h100);
    check_log("t2_reps", base + 6, 1'b1, 64'hF8, 64'd4);
    check_log("t2_next", base + 7, 1'b0, 64'h10, 64'h0);
    finish_done(32'd5, 2'd0);

    // three polls, spaced by the poll interval
    done_seq = '{32'd3, 32'd4, 32'd5, 32'd5};
    start_job(64'h10, 64'h20, 32'h8, 8'h00, 64'h0, 64'h0, 64'h0, base);
    wait_done();
    check_eq("t3_polls", 64'(count_rd18(base)), 64'd3);
    pc = -1;
    for (int i = base; i < n_log && i < 256; i++) begin
      if (!log_wr[i] && log_addr[i] == 64'h18) begin
        if (pc >= 0) check_eq("t3_spacing", 64'(log_cyc[i] - pc >= 16), 64'd1);
        pc = log_cyc[i];
      end
    end
    finish_done(32'd5, 2'd0);

    // 32-bit wrap of DONE_ID
    next_id_val = 32'h1;
    done_seq = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'h1};
    start_job(64'h10, 64'h20, 32'h8, 8'h00, 64'h0, 64'h0, 64'h0, base);
    wait_done();
    check_eq("t4_polls", 64'(count_rd18(base)), 64'd2);
    finish_done(32'h1, 2'd0);

    // bus error on the DST write
    err_en = 1'b1; err_addr = 64'hD0;
    start_job(64'h10, 64'h20, 32'h8, 8'h00, 64'h0, 64'h0, 64'h0, base);
    wait_done();
    repeat (3) @(negedge clk_i);
    check_eq("t5_count", 64'(n_log - base), 64'd3);
    check_eq("t5_no_req", 64'(reg_valid_o), 64'd0);
    finish_done(32'd0, 2'd1);
    err_en = 1'b0;

    // NEXT_ID of zero is rejected
    next_id_val = 32'd0;
    start_job(64'h10, 64'h20, 32'h8, 8'h00, 64'h0, 64'h0, 64'h0, base);
    wait_done();
    check_eq("t6_count", 64'(n_log - base), 64'd5);
    check_eq("t6_polls", 64'(count_rd18(base)), 64'd0);
    finish_done(32'd0, 2'd2);

    // register and completion backpressure
    next_id_val = 32'd7;
    done_seq = '{32'd7, 32'd7, 32'd7, 32'd7};
    start_job(64'hA000, 64'hB000, 32'h10, 8'h00, 64'h0, 64'h0, 64'h0, base);
    n = 0;
    while (!(reg_valid_o && reg_addr_o == 64'hD0) && n < 20) begin @(negedge clk_i); n++; end
    bus_hold = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check_eq("t7_hold_valid", 64'(reg_valid_o), 64'd1);
      check_eq("t7_hold_addr", reg_addr_o, 64'hD0);
      check_eq("t7_hold_data", reg_wdata_o, 64'hB000);
    end
    bus_hold = 1'b0;
    wait_done();
    check_eq("t7_count", 64'(n_log - base), 64'd6);
    repeat (3) begin
      @(negedge clk_i);
      check_eq("t7_rec_valid", 64'(done_valid_o), 64'd1);
      check_eq("t7_rec_id", 64'(done_id_o), 64'd7);
      check_eq("t7_not_ready", 64'(job_ready_o), 64'd0);
    end
    finish_done(32'd7, 2'd0);

    // reset while waiting between polls
    next_id_val = 32'd9;
    done_seq = '{32'd0, 32'd0, 32'd0, 32'd0};
    start_job(64'h10, 64'h20, 32'h8, 8'h00, 64'h0, 64'h0, 64'h0, base);
    n = 0;
    while (n_log < base + 5 && n < 50) begin @(negedge clk_i); n++; end
    repeat (3) @(negedge clk_i);
    check_eq("t8_in_wait", 64'(reg_valid_o), 64'd0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_eq("t8_reg_valid", 64'(reg_valid_o), 64'd0);
    check_eq("t8_done_valid", 64'(done_valid_o), 64'd0);
    check_eq("t8_addr", reg_addr_o, 64'd0);
    check_eq("t8_job_ready", 64'(job_ready_o), 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("t8_ready_after", 64'(job_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
